// File: rtl/led_fade_pwm.sv
// Per-channel PWM LED driver whose brightness ramps linearly toward a 0/1 target pattern.
// Latency: pattern->target 1 clk, level step per prescaler tick, level->led_out 1 clk (2 clk with LED_FADE_GAMMA_EN). No backpressure.
module led_fade_pwm #(
  parameter int N_LED     = 4,
  parameter int PWM_BITS  = 8,
  parameter int STEP_LOG2 = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_LED-1:0]          pattern_in,
  output logic [N_LED-1:0]          led_out,
  output logic [N_LED*PWM_BITS-1:0] level_out,
  output logic                      idle
);

  localparam logic [PWM_BITS-1:0]  LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0]  LVL_ONE = PWM_BITS'(1);
  localparam logic [STEP_LOG2-1:0] PRE_ONE = STEP_LOG2'(1);

  typedef enum logic [1:0] {
    CH_OFF,
    CH_RISE,
    CH_ON,
    CH_FALL
  } ch_state_t;

  logic [N_LED-1:0]     target;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [STEP_LOG2-1:0] prescaler;
  logic                 tick;
  logic [PWM_BITS-1:0]  level [N_LED];
  ch_state_t            state [N_LED];
  logic                 all_settled;

  logic [PWM_BITS-1:0]  duty [N_LED];
  logic [N_LED-1:0]     force_on;
  logic [N_LED-1:0]     force_off;

  assign tick = &prescaler;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      target    <= '0;
      pwm_cnt   <= '0;
      prescaler <= '0;
    end else begin
      target    <= pattern_in;
      pwm_cnt   <= pwm_cnt + LVL_ONE;
      prescaler <= prescaler + PRE_ONE;
    end
  end

  // Channel state is a pure function of (target, level), so a reversal simply
  // flips direction from wherever the level currently is.
  always_comb begin
    all_settled = 1'b1;
    for (int i = 0; i < N_LED; i++) begin
      state[i] = CH_OFF;
      if (target[i]) begin
        state[i] = (level[i] == LVL_MAX) ? CH_ON : CH_RISE;
      end else begin
        state[i] = (level[i] == '0) ? CH_OFF : CH_FALL;
      end
      if (state[i] == CH_RISE || state[i] == CH_FALL) begin
        all_settled = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_LED; i++) begin
        level[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < N_LED; i++) begin
        case (state[i])
          CH_RISE: level[i] <= level[i] + LVL_ONE;
          CH_FALL: level[i] <= level[i] - LVL_ONE;
          default: level[i] <= level[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle <= 1'b1;
    end else begin
      idle <= all_settled;
    end
  end

  always_comb begin
    level_out = '0;
    for (int i = 0; i < N_LED; i++) begin
      level_out[i*PWM_BITS +: PWM_BITS] = level[i];
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] lvl_sq [N_LED];

  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      lvl_sq[i] = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
    end
  end

  // Force flags travel with the squared duty so both reach led_out in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_LED; i++) begin
        duty[i] <= '0;
      end
      force_on  <= '0;
      force_off <= '1;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        duty[i]      <= PWM_BITS'(lvl_sq[i] >> PWM_BITS);
        force_on[i]  <= (level[i] == LVL_MAX);
        force_off[i] <= (level[i] == '0);
      end
    end
  end
`else
  always_comb begin
    force_on  = '0;
    force_off = '0;
    for (int i = 0; i < N_LED; i++) begin
      duty[i]      = level[i];
      force_on[i]  = (level[i] == LVL_MAX);
      force_off[i] = (level[i] == '0);
    end
  end
`endif

  // Full scale is forced high: duty > pwm_cnt alone would drop out at cnt == MAX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_out <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        led_out[i] <= force_on[i] | (~force_off[i] & (duty[i] > pwm_cnt));
      end
    end
  end

endmodule
